drf_wport_arbiter: RTL and testbench

Arbiter and sequencer for the single write port of the DRF 8×8 register file. Up to three requesters compete for the port: ALU writeback, memory load and I/O port input. It grants one write per cycle, round-robin by default, and drives the register file's `reg_write_en`, `in_rx_selector` and `reg_in_data` from a registered stage. It sits inside `drf_system` between the execution units and the register file.

---
 rtl/drf_wport_arbiter.sv | 106 ++++++++++
 tb/tb_drf_wport_arbiter.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/drf_wport_arbiter.sv
// Write-port arbiter/sequencer for the DRF 8x8 register file: grants one requester per cycle
// and drives the register-file write port from a registered stage. Round-robin by default;
// defining DRF_ARB_FIXED_PRIO_EN selects fixed priority (index 0 highest).
module drf_wport_arbiter #(
  parameter int unsigned N_REQ  = 3,
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned DATA_W = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      stall,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*ADDR_W-1:0]   req_addr,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  output logic [N_REQ-1:0]          gnt,
  output logic                      reg_write_en,
  output logic [ADDR_W-1:0]         in_rx_selector,
  output logic [DATA_W-1:0]         reg_in_data,
  output logic [1:0]                arb_ptr,
  output logic [15:0]               write_count
);

  logic [N_REQ-1:0]  elig;
  logic [1:0]        cur_ptr;
  logic [1:0]        gnt_idx;
  logic              gnt_any;
  int unsigned       scan_idx;

  logic              we_q;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [15:0]       cnt_q, cnt_d;

`ifdef DRF_ARB_FIXED_PRIO_EN
  // Scanning from a constant 0 is exactly fixed priority.
  assign cur_ptr = 2'd0;
`else
  logic [1:0] ptr_q, ptr_d;

  assign cur_ptr = ptr_q;

  always_comb begin
    ptr_d = ptr_q;
    if (gnt_any) begin
      ptr_d = (gnt_idx == 2'(N_REQ - 1)) ? 2'd0 : gnt_idx + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= 2'd0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`endif

  // Scan from cur_ptr upward modulo N_REQ; first eligible requester wins.
  always_comb begin
    elig     = req & {N_REQ{~stall & ~reset}};
    gnt      = '0;
    gnt_idx  = 2'd0;
    gnt_any  = 1'b0;
    scan_idx = 0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      scan_idx = (32'(cur_ptr) + k) % N_REQ;
      if (!gnt_any && elig[scan_idx]) begin
        gnt_any       = 1'b1;
        gnt[scan_idx] = 1'b1;
        gnt_idx       = scan_idx[1:0];
      end
    end
  end

  always_comb begin
    addr_d = addr_q;
    data_d = data_q;
    cnt_d  = cnt_q;
    if (gnt_any) begin
      addr_d = req_addr[gnt_idx*ADDR_W +: ADDR_W];
      data_d = req_data[gnt_idx*DATA_W +: DATA_W];
      cnt_d  = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      we_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      cnt_q  <= 16'd0;
    end else begin
      we_q   <= gnt_any;
      addr_q <= addr_d;
      data_q <= data_d;
      cnt_q  <= cnt_d;
    end
  end

  assign reg_write_en   = we_q;
  assign in_rx_selector = addr_q;
  assign reg_in_data    = data_q;
  assign write_count    = cnt_q;
  assign arb_ptr        = cur_ptr;

endmodule

// File: tb/tb_drf_wport_arbiter.sv
// Self-checking bench for drf_wport_arbiter: table-driven vectors with a write scoreboard,
// plus hand-written reset-mid-operation and counter-wrap sequences.
module tb_drf_wport_arbiter;

  localparam int unsigned N_REQ  = 3;
  localparam int unsigned ADDR_W = 3;
  localparam int unsigned DATA_W = 8;

  logic                    clk = 1'b0;
  logic                    reset;
  logic                    stall;
  logic [N_REQ-1:0]        req;
  logic [N_REQ*ADDR_W-1:0] req_addr;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic [N_REQ-1:0]        gnt;
  logic                    reg_write_en;
  logic [ADDR_W-1:0]       in_rx_selector;
  logic [DATA_W-1:0]       reg_in_data;
  logic [1:0]              arb_ptr;
  logic [15:0]             write_count;

  drf_wport_arbiter #(
    .N_REQ (N_REQ),
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .req           (req),
    .req_addr      (req_addr),
    .req_data      (req_data),
    .gnt           (gnt),
    .reg_write_en  (reg_write_en),
    .in_rx_selector(in_rx_selector),
    .reg_in_data   (reg_in_data),
    .arb_ptr       (arb_ptr),
    .write_count   (write_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  req;
    logic        stall;
    logic [8:0]  addr;
    logic [23:0] data;
    logic [2:0]  g_rr;
    logic [2:0]  g_fp;
  } vec_t;

  typedef struct {
    logic [2:0] addr;
    logic [7:0] data;
  } wr_t;

  vec_t        vecs[$];
  wr_t         sb[$];
  logic [7:0]  rf[8];
  int          pass_cnt  = 0;
  int          total_cnt = 0;
  logic [1:0]  ptr_m = 2'd0;
  logic [15:0] cnt_m = 16'd0;

`ifdef DRF_ARB_FIXED_PRIO_EN
  localparam bit FixedPrio = 1'b1;
`else
  localparam bit FixedPrio = 1'b0;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic add(input logic [2:0] r, input logic s, input logic [8:0] a,
                     input logic [23:0] d, input logic [2:0] grr, input logic [2:0] gfp);
    vec_t v;
    v.req = r; v.stall = s; v.addr = a; v.data = d; v.g_rr = grr; v.g_fp = gfp;
    vecs.push_back(v);
  endtask

  // Starts and ends 1 time unit after a rising edge.
  task automatic apply(input vec_t v);
    logic [2:0] eg;
    int         idx;
    wr_t        w;
    req = v.req; stall = v.stall; req_addr = v.addr; req_data = v.data;
    #2;
    eg = FixedPrio ? v.g_fp : v.g_rr;
    chk("gnt", 32'(gnt), 32'(eg));
    idx = -1;
    for (int i = 0; i < 3; i++) if (eg[i]) idx = i;
    if (idx >= 0) begin
      w.addr = v.addr[idx*3 +: 3];
      w.data = v.data[idx*8 +: 8];
      sb.push_back(w);
      ptr_m = FixedPrio ? 2'd0 : 2'((idx + 1) % 3);
      cnt_m = cnt_m + 16'd1;
    end
    @(posedge clk); #1;
    chk("reg_write_en", 32'(reg_write_en), 32'(idx >= 0));
    if (idx >= 0 && sb.size() > 0) begin
      w = sb.pop_front();
      chk("in_rx_selector", 32'(in_rx_selector), 32'(w.addr));
      chk("reg_in_data", 32'(reg_in_data), 32'(w.data));
    end
    if (reg_write_en) rf[in_rx_selector] = reg_in_data;
    chk("arb_ptr", 32'(arb_ptr), 32'(ptr_m));
    chk("write_count", 32'(write_count), 32'(cnt_m));
  endtask

  initial begin
    for (int i = 0; i < 8; i++) rf[i] = 8'h00;
    reset = 1'b1; stall = 1'b0; req = 3'b111; req_addr = '1; req_data = '1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_we", 32'(reg_write_en), 0);
    chk("rst_addr", 32'(in_rx_selector), 0);
    chk("rst_data", 32'(reg_in_data), 0);
    chk("rst_ptr", 32'(arb_ptr), 0);
    chk("rst_cnt", 32'(write_count), 0);
    reset = 1'b0;

    // Single request, then steer pointer back to 0 for the rotation run.
    add(3'b010, 1'b0, {3'd0, 3'd5, 3'd0}, {8'h00, 8'hA7, 8'h00}, 3'b010, 3'b010);
    add(3'b100, 1'b0, {3'd6, 3'd0, 3'd0}, {8'h5C, 8'h00, 8'h00}, 3'b100, 3'b100);
    for (int i = 0; i < 6; i++) begin
      logic [7:0] b;
      b = 8'(i);
      add(3'b111, 1'b0, {3'd4, 3'd2, 3'd1}, {8'h20 + b, 8'h10 + b, 8'h00 + b},
          3'(1 << (i % 3)), 3'b001);
    end
    for (int i = 0; i < 3; i++)
      add(3'b001, 1'b1, {3'd0, 3'd0, 3'd7}, {8'h00, 8'h00, 8'hEE}, 3'b000, 3'b000);
    add(3'b001, 1'b0, {3'd0, 3'd0, 3'd7}, {8'h00, 8'h00, 8'hEE}, 3'b001, 3'b001);
    add(3'b000, 1'b0, 9'd0, 24'd0, 3'b000, 3'b000);
    add(3'b100, 1'b0, {3'd2, 3'd0, 3'd0}, {8'h77, 8'h00, 8'h00}, 3'b100, 3'b100);
    // Same destination r3 from requesters 0 and 1; 0 drops req after its grant.
    add(3'b011, 1'b0, {3'd0, 3'd3, 3'd3}, {8'h00, 8'h22, 8'h11}, 3'b001, 3'b001);
    add(3'b010, 1'b0, {3'd0, 3'd3, 3'd3}, {8'h00, 8'h22, 8'h11}, 3'b010, 3'b010);
    add(3'b000, 1'b0, 9'd0, 24'd0, 3'b000, 3'b000);

    foreach (vecs[i]) apply(vecs[i]);
    chk("r3_final", 32'(rf[3]), 32'h22);

    // Reset mid-operation: grant to requester 2, reset high at that edge.
    req = 3'b100; req_addr = {3'd5, 3'd0, 3'd0}; req_data = {8'h99, 8'h00, 8'h00};
    #2;
    chk("mid_gnt", 32'(gnt), 32'b100);
    reset = 1'b1;
    #1;
    chk("mid_gnt_rst", 32'(gnt), 0);
    @(posedge clk); #1;
    chk("mid_we", 32'(reg_write_en), 0);
    chk("mid_ptr", 32'(arb_ptr), 0);
    chk("mid_cnt", 32'(write_count), 0);
    chk("mid_data", 32'(reg_in_data), 0);
    sb.delete();
    reset = 1'b0;

    // Counter wrap: 65535 back-to-back writes, then one more.
    req = 3'b001; stall = 1'b0; req_addr = {3'd0, 3'd0, 3'd1}; req_data = {8'h0, 8'h0, 8'h3C};
    repeat (65535) @(posedge clk);
    #1;
    chk("wrap_ffff", 32'(write_count), 32'hFFFF);
    chk("wrap_we", 32'(reg_write_en), 1);
    @(posedge clk); #1;
    chk("wrap_zero", 32'(write_count), 0);
    req = 3'b000;

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
